// File: rtl/search_window_pingpong_mem_if.sv
// Load-stream, swap handshake and multi-port read bus of the ping-pong search-window store.
// The master drives the load/swap/read requests; the slave is the memory block.
interface search_window_pingpong_mem_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_RD_PORTS = 2
);
  logic                               in_load_start;
  logic                               in_wr_valid;
  logic [DATA_WIDTH-1:0]              in_wr_data;
  logic                               out_wr_ready;
  logic                               out_load_done;
  logic                               in_swap;
  logic                               out_bank_ready;
  logic                               out_active_bank;
  logic                               in_rd_en;
  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] in_rd_addr;
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] out_rd_data;
  logic                               out_rd_valid;

  modport master (
    output in_load_start, in_wr_valid, in_wr_data, in_swap, in_rd_en, in_rd_addr,
    input  out_wr_ready, out_load_done, out_bank_ready, out_active_bank, out_rd_data, out_rd_valid
  );

  modport slave (
    input  in_load_start, in_wr_valid, in_wr_data, in_swap, in_rd_en, in_rd_addr,
    output out_wr_ready, out_load_done, out_bank_ready, out_active_bank, out_rd_data, out_rd_valid
  );
endinterface

// File: rtl/search_window_pingpong_mem.sv
// Double-buffered search-window pixel store: a load stream fills the inactive bank while
// NUM_RD_PORTS readers see the active bank; a swap in FULL makes the new window active.
module search_window_pingpong_mem #(
  parameter int DATA_WIDTH   = 8,
  parameter int WIN_SIZE     = 31,
  parameter int MEMORY_DEPTH = 961,
  parameter int NUM_RD_PORTS = 2,
  parameter int ADDR_WIDTH   = $clog2(MEMORY_DEPTH)
) (
  input  logic                          in_clk,
  input  logic                          in_rst,
  search_window_pingpong_mem_if.slave   bus
);

  localparam int IDX_W = $clog2(2 * MEMORY_DEPTH);

  if (MEMORY_DEPTH != WIN_SIZE * WIN_SIZE) begin : g_depth_check
    $error("MEMORY_DEPTH must equal WIN_SIZE*WIN_SIZE");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic                    active_q, active_d;
  logic                    bank_ready_q, bank_ready_d;
  logic                    load_done_q, load_done_d;
  logic                    rd_valid_q;
  logic                    wr_ready;
  logic                    wr_accept;
  logic                    last_beat;
  logic [IDX_W-1:0]        wr_idx;

  // Both banks share one array: bank b occupies [b*MEMORY_DEPTH +: MEMORY_DEPTH].
  logic [DATA_WIDTH-1:0]   mem [2*MEMORY_DEPTH];

  assign wr_accept = wr_ready & bus.in_wr_valid;
  assign last_beat = (wr_addr_q == ADDR_WIDTH'(MEMORY_DEPTH - 1));
  assign wr_idx    = active_q ? IDX_W'(wr_addr_q) : IDX_W'(MEMORY_DEPTH) + IDX_W'(wr_addr_q);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q      <= S_IDLE;
      wr_addr_q    <= '0;
      active_q     <= 1'b0;
      bank_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      active_q     <= active_d;
      bank_ready_q <= bank_ready_d;
      load_done_q  <= load_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    active_d     = active_q;
    bank_ready_d = bank_ready_q;
    load_done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_load_start) begin
          state_d   = S_LOAD;
          wr_addr_d = '0;
        end
      end
      S_LOAD: begin
        if (wr_accept) begin
          wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
          if (last_beat) begin
            state_d     = S_FULL;
            load_done_d = 1'b1;
          end
        end
      end
      S_FULL: begin
        if (bus.in_swap) begin
          state_d      = S_IDLE;
          active_d     = ~active_q;
          bank_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ready = (state_q == S_LOAD);
  end

  always_ff @(posedge in_clk) begin
    if (wr_accept) begin
      mem[wr_idx] <= bus.in_wr_data;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.in_rd_en & bank_ready_q;
    end
  end

  // Raw read registers carry no reset so they map onto RAM output latches; the
  // reset-capable seen/out-of-range flags force the visible data to zero instead.
  for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd_port
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  oor;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] raw_q;
    logic                  oor_q;
    logic                  seen_q;

    assign rd_addr = bus.in_rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign oor     = (32'(rd_addr) >= MEMORY_DEPTH);
    assign rd_idx  = (active_q ? IDX_W'(MEMORY_DEPTH) : IDX_W'(0)) + (oor ? IDX_W'(0) : IDX_W'(rd_addr));

    always_ff @(posedge in_clk) begin
      if (bus.in_rd_en) begin
        raw_q <= mem[rd_idx];
      end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
        oor_q  <= 1'b0;
        seen_q <= 1'b0;
      end else if (bus.in_rd_en) begin
        oor_q  <= oor;
        seen_q <= 1'b1;
      end
    end

    assign bus.out_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = (seen_q && !oor_q) ? raw_q : '0;
  end

  assign bus.out_wr_ready    = wr_ready;
  assign bus.out_load_done   = load_done_q;
  assign bus.out_bank_ready  = bank_ready_q;
  assign bus.out_active_bank = active_q;
  assign bus.out_rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_search_window_pingpong_mem.sv
// Directed bench for search_window_pingpong_mem: reset, fill/swap, stalls, ping-pong reads,
// ignored requests, out-of-range reads and reset in the middle of a load.
module tb_search_window_pingpong_mem;

  localparam int DEPTH = 961;
  localparam int AW    = 10;
  localparam int DW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  search_window_pingpong_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD_PORTS(2)) bus ();

  search_window_pingpong_mem #(
    .DATA_WIDTH(DW), .WIN_SIZE(31), .MEMORY_DEPTH(DEPTH), .NUM_RD_PORTS(2)
  ) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_mem [2][DEPTH];
  logic          exp_active     = 1'b0;
  logic          exp_bank_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pix(input bit inv, input int a);
    logic [DW-1:0] v;
    v = a[7:0];
    return inv ? ~v : v;
  endfunction

  function automatic logic [DW-1:0] rd_exp(input int a);
    if (a >= DEPTH) return '0;
    return exp_mem[exp_active][a];
  endfunction

  task automatic check_read(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                            input logic ev);
    check({tag, "_p0"}, bus.out_rd_data[7:0], e0);
    check({tag, "_p1"}, bus.out_rd_data[15:8], e1);
    check({tag, "_valid"}, bus.out_rd_valid, ev);
  endtask

  task automatic read2(input string tag, input int a0, input int a1);
    logic [DW-1:0] e0, e1;
    logic ev;
    e0 = rd_exp(a0);
    e1 = rd_exp(a1);
    ev = exp_bank_ready;
    bus.in_rd_en   = 1'b1;
    bus.in_rd_addr = {AW'(a1), AW'(a0)};
    step();
    bus.in_rd_en = 1'b0;
    check_read(tag, e0, e1, ev);
    $display("read %s: addr %0d/%0d -> %02h/%02h valid %0b", tag, a0, a1,
             bus.out_rd_data[7:0], bus.out_rd_data[15:8], bus.out_rd_valid);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_ready"},    bus.out_wr_ready, 0);
    check({tag, "_load_done"},   bus.out_load_done, 0);
    check({tag, "_bank_ready"},  bus.out_bank_ready, 0);
    check({tag, "_active_bank"}, bus.out_active_bank, 0);
    check({tag, "_rd_data"},     bus.out_rd_data, 0);
    check({tag, "_rd_valid"},    bus.out_rd_valid, 0);
  endtask

  // Fill the inactive bank; optionally stall every 3rd cycle and read the active bank each cycle.
  // A stray swap and load_start are injected mid-load and must be ignored.
  task automatic do_load(input bit inv, input bit stall, input bit rd, input int stop_at);
    int i, cyc, dones, a0, a1;
    logic v, ev;
    logic [DW-1:0] e0, e1;
    bus.in_load_start = 1'b1;
    bus.in_wr_valid   = 1'b1;
    bus.in_wr_data    = pix(inv, 0);
    check("idle_wr_ready", bus.out_wr_ready, 0);
    step();
    bus.in_load_start = 1'b0;
    i = 0; cyc = 0; dones = 0;
    while (i < stop_at && cyc < 4000) begin
      v = !(stall && (cyc % 3 == 2));
      bus.in_wr_valid   = v;
      bus.in_wr_data    = pix(inv, i);
      bus.in_swap       = (cyc == 100);
      bus.in_load_start = (cyc == 101);
      a0 = cyc % DEPTH;
      a1 = (cyc * 7 + 3) % DEPTH;
      bus.in_rd_en   = rd;
      bus.in_rd_addr = {AW'(a1), AW'(a0)};
      e0 = rd_exp(a0);
      e1 = rd_exp(a1);
      ev = exp_bank_ready;
      check("load_wr_ready", bus.out_wr_ready, 1);
      step();
      cyc++;
      if (v) begin
        exp_mem[~exp_active][i] = pix(inv, i);
        i++;
      end
      if (bus.out_load_done) dones++;
      if (rd) check_read("load_rd", e0, e1, ev);
    end
    bus.in_wr_valid = 1'b0; bus.in_swap = 1'b0; bus.in_load_start = 1'b0; bus.in_rd_en = 1'b0;
    check("load_beats", i, stop_at);
    check("load_active_hold", bus.out_active_bank, exp_active);
    $display("load inv=%0b stall=%0b: %0d beats in %0d cycles, %0d done pulses", inv, stall, i, cyc, dones);
    if (stop_at == DEPTH) begin
      check("load_done_pulse", bus.out_load_done, 1);
      check("load_done_count", dones, 1);
      step();
      check("load_done_clear", bus.out_load_done, 0);
      check("full_wr_ready", bus.out_wr_ready, 0);
      bus.in_load_start = 1'b1;
      step();
      bus.in_load_start = 1'b0;
      check("full_ignores_start", bus.out_wr_ready, 0);
    end
  endtask

  task automatic do_swap(input bit rd, input int a0, input int a1);
    logic [DW-1:0] e0, e1;
    logic ev;
    e0 = rd_exp(a0);
    e1 = rd_exp(a1);
    ev = exp_bank_ready;
    bus.in_swap    = 1'b1;
    bus.in_rd_en   = rd;
    bus.in_rd_addr = {AW'(a1), AW'(a0)};
    step();
    bus.in_swap  = 1'b0;
    bus.in_rd_en = 1'b0;
    exp_active     = ~exp_active;
    exp_bank_ready = 1'b1;
    check("swap_active", bus.out_active_bank, exp_active);
    check("swap_bank_ready", bus.out_bank_ready, 1);
    if (rd) check_read("swap_rd", e0, e1, ev);
    $display("swap: active bank now %0b", bus.out_active_bank);
  endtask

  initial begin
    bus.in_load_start = 1'b0;
    bus.in_wr_valid   = 1'b0;
    bus.in_wr_data    = '0;
    bus.in_swap       = 1'b0;
    bus.in_rd_en      = 1'b0;
    bus.in_rd_addr    = '0;

    // Reset state
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check("idle_wr_ready0", bus.out_wr_ready, 0);

    // Swap in IDLE and reads without a ready bank
    bus.in_swap = 1'b1;
    step();
    bus.in_swap = 1'b0;
    check("idle_swap_active", bus.out_active_bank, 0);
    check("idle_swap_bank_ready", bus.out_bank_ready, 0);
    bus.in_rd_en = 1'b1;
    step();
    bus.in_rd_en = 1'b0;
    check("no_bank_rd_valid", bus.out_rd_valid, 0);

    // Plain fill of bank 1 with addr[7:0], then swap
    do_load(1'b0, 1'b0, 1'b0, DEPTH);
    do_swap(1'b0, 0, 0);
    check("t2_active_is_1", bus.out_active_bank, 1);
    read2("t2", 0, 960);
    check("t2_p0_hand", bus.out_rd_data[7:0], 8'h00);
    check("t2_p1_hand", bus.out_rd_data[15:8], 8'hC0);

    // Out-of-range address zeroes only its own port; data holds when rd_en is low
    read2("oor_p0", 1000, 5);
    check("oor_p1_hand", bus.out_rd_data[15:8], 8'h05);
    read2("oor_p1", 7, 1000);
    check("oor_p0_hand", bus.out_rd_data[7:0], 8'h07);
    step();
    check("hold_data", bus.out_rd_data, 16'h0007);
    check("hold_valid", bus.out_rd_valid, 0);

    // Stalled fill of bank 0 with ~addr while reading bank 1 every cycle
    do_load(1'b1, 1'b1, 1'b1, DEPTH);
    do_swap(1'b1, 3, 4);
    check("swap_rd_old_hand", bus.out_rd_data, 16'h0403);
    read2("t4_new", 3, 4);
    check("t4_new_hand", bus.out_rd_data, 16'hFBFC);
    read2("t3_ends", 0, 960);
    check("t3_ends_hand", bus.out_rd_data, 16'h3FFF);
    read2("t3_mid_a", 1, 2);
    read2("t3_mid_b", 479, 480);
    read2("t3_mid_c", 958, 959);

    // Reset in the middle of a load, asserted between clock edges
    do_load(1'b0, 1'b0, 1'b1, 500);
    check("abort_pre_valid", bus.out_rd_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_active     = 1'b0;
    exp_bank_ready = 1'b0;
    step();
    check("post_rst_wr_ready", bus.out_wr_ready, 0);
    check("post_rst_bank_ready", bus.out_bank_ready, 0);
    check("post_rst_active", bus.out_active_bank, 0);

    // Full reload after reset; bank 0 contents survive reset but are not yet valid to readers
    do_load(1'b0, 1'b0, 1'b1, DEPTH);
    do_swap(1'b1, 10, 960);
    read2("t6_ends", 0, 960);
    check("t6_ends_hand", bus.out_rd_data, 16'hC000);
    read2("t6_mid", 500, 499);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
